// File: rtl/load_align_ext_pkg.sv
// load_align_ext_pkg: size encodings and width helpers shared by the load aligner
package load_align_ext_pkg;
    typedef enum logic [1:0] {
        SZ_FULL     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_BYTE     = 2'd2,
        SZ_FULL_ALT = 2'd3
    } size_e;
    localparam int DATA_W_DEF = 32;
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/load_extract_comb.sv
// load_extract_comb: byte/half lane select, sign/zero extension and misalign check
module load_extract_comb
    import load_align_ext_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] res,
    output logic              misalign
);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] bext, hext;
    logic              is_full;
    always_comb begin
        b        = 8'(data >> {off, 3'b000});
        // half lane is picked by off[MSB:1] so a misaligned offset never reads past the MSB
        h        = 16'(data >> {off[OFF_W-1:1], 4'b0000});
        bext     = {{(DATA_W-8){sgn & b[7]}}, b};
        hext     = {{(DATA_W-16){sgn & h[15]}}, h};
        is_full  = size == SZ_FULL || size == SZ_FULL_ALT;
        misalign = (size == SZ_HALF && off[0]) || (is_full && off != '0);
        res      = misalign ? '0 : size == SZ_BYTE ? bext : size == SZ_HALF ? hext : data;
    end
endmodule

// File: rtl/load_align_ext.sv
// load_align_ext: pipelined load-data aligner/extender with valid/ready handshake and flush
module load_align_ext
    import load_align_ext_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OFF_W       = off_w(DATA_W),
    parameter int PIPE_STAGES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);
    logic              v0, m0, go0, x_mis;
    logic [DATA_W-1:0] d0, x_data;
    load_extract_comb #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_extract (
        .data     (in_data),
        .off      (in_off),
        .size     (in_size),
        .sgn      (in_signed),
        .res      (x_data),
        .misalign (x_mis)
    );
    assign in_ready = go0;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v0 <= 1'b0;
            d0 <= '0;
            m0 <= 1'b0;
        end else if (flush) begin
            v0 <= 1'b0;
        end else if (go0) begin
            v0 <= in_valid;
            d0 <= x_data;
            m0 <= x_mis;
        end
    end
    if (PIPE_STAGES == 2) begin : g_two
        logic              v1, m1, go1;
        logic [DATA_W-1:0] d1;
        assign go1          = !v1 || out_ready;
        assign go0          = !v0 || go1;
        assign out_valid    = v1;
        assign out_data     = d1;
        assign out_misalign = m1;
        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                v1 <= 1'b0;
                d1 <= '0;
                m1 <= 1'b0;
            end else if (flush) begin
                v1 <= 1'b0;
            end else if (go1) begin
                v1 <= v0;
                d1 <= d0;
                m1 <= m0;
            end
        end
    end else begin : g_one
        assign go0          = !v0 || out_ready;
        assign out_valid    = v0;
        assign out_data     = d0;
        assign out_misalign = m0;
    end
endmodule

// File: tb/tb_load_align_ext.sv
// tb_load_align_ext: scoreboard bench for a 32-bit/1-stage and a 64-bit/2-stage aligner
module tb_load_align_ext;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_valid, a_in_ready, a_in_signed, a_flush, a_out_valid, a_out_ready, a_out_misalign;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_in_off, a_in_size;
    logic [32:0] a_exp, a_want;
    logic [32:0] qa[$];

    logic        b_in_valid, b_in_ready, b_in_signed, b_flush, b_out_valid, b_out_ready, b_out_misalign;
    logic [63:0] b_in_data, b_out_data;
    logic [2:0]  b_in_off;
    logic [1:0]  b_in_size;
    logic [64:0] b_exp, b_want;
    logic [64:0] qb[$];
    int          b_pops = 0;

    load_align_ext #(.DATA_W(32), .PIPE_STAGES(1)) u_a (
        .Clk(clk), .Reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_off(a_in_off), .in_size(a_in_size), .in_signed(a_in_signed),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_misalign(a_out_misalign)
    );
    load_align_ext #(.DATA_W(64), .PIPE_STAGES(2)) u_b (
        .Clk(clk), .Reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_off(b_in_off), .in_size(b_in_size), .in_signed(b_in_signed),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_misalign(b_out_misalign)
    );

    always @(negedge clk) begin
        if (!rst_n || a_flush) qa.delete();
        else begin
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_out unexpected result mis=%b data=%h", a_out_misalign, a_out_data);
                end else begin
                    a_want = qa.pop_front();
                    if ({a_out_misalign, a_out_data} !== a_want) begin
                        errors++;
                        $display("FAIL a_out got mis=%b data=%h want mis=%b data=%h",
                                 a_out_misalign, a_out_data, a_want[32], a_want[31:0]);
                    end
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(a_exp);
        end
    end

    always @(negedge clk) begin
        if (!rst_n || b_flush) qb.delete();
        else begin
            if (b_out_valid && b_out_ready) begin
                checks++;
                b_pops++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_out unexpected result mis=%b data=%h", b_out_misalign, b_out_data);
                end else begin
                    b_want = qb.pop_front();
                    if ({b_out_misalign, b_out_data} !== b_want) begin
                        errors++;
                        $display("FAIL b_out got mis=%b data=%h want mis=%b data=%h",
                                 b_out_misalign, b_out_data, b_want[64], b_want[63:0]);
                    end
                end
            end
            if (b_in_valid && b_in_ready) qb.push_back(b_exp);
        end
    end

    function automatic logic [32:0] model_a(input logic [31:0] d, input logic [1:0] o,
                                            input logic [1:0] s, input logic sg);
        logic [7:0]  by[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
        if (s == 2'd2) begin
            r = {24'b0, by[o]};
            if (sg && by[o][7]) r[31:8] = '1;
            return {1'b0, r};
        end
        if (s == 2'd1) begin
            if (o[0]) return {1'b1, 32'b0};
            r = {16'b0, by[o+1], by[o]};
            if (sg && by[o+1][7]) r[31:16] = '1;
            return {1'b0, r};
        end
        if (o != 2'd0) return {1'b1, 32'b0};
        return {1'b0, d};
    endfunction

    task automatic a_send(input logic [31:0] d, input logic [1:0] o, input logic [1:0] s,
                          input logic sg, input logic [32:0] e);
        int n;
        a_in_data = d; a_in_off = o; a_in_size = s; a_in_signed = sg; a_exp = e; a_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept timeout in_ready=%b required 1", a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [63:0] d, input logic [2:0] o, input logic [1:0] s,
                          input logic sg, input logic [64:0] e);
        int n;
        b_in_data = d; b_in_off = o; b_in_size = s; b_in_signed = sg; b_exp = e; b_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) begin
            checks++;
            errors++;
            $display("FAIL b_accept timeout in_ready=%b required 1", b_in_ready);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        checks += 6;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset a_out_valid got %b want 0", a_out_valid); end
        if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset a_out_data got %h want 0", a_out_data); end
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset a_in_ready got %b want 1", a_in_ready); end
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset b_out_valid got %b want 0", b_out_valid); end
        if (b_out_data !== 64'h0) begin errors++; $display("FAIL reset b_out_data got %h want 0", b_out_data); end
        if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset b_in_ready got %b want 1", b_in_ready); end
    endtask

    task automatic test_byte_signed();
        a_out_ready = 1'b1;
        a_send(32'h12F45678, 2'd2, 2'd2, 1'b1, {1'b0, 32'hFFFFFFF4});
        @(negedge clk);
        checks += 2;
        if (a_out_valid !== 1'b1) begin errors++; $display("FAIL byte_s latency out_valid got %b want 1", a_out_valid); end
        if (a_out_data !== 32'hFFFFFFF4) begin errors++; $display("FAIL byte_s data got %h want FFFFFFF4", a_out_data); end
        @(posedge clk); #1;
        a_send(32'h12F45678, 2'd2, 2'd2, 1'b0, {1'b0, 32'h000000F4});
        @(negedge clk);
        checks += 2;
        if (a_out_valid !== 1'b1) begin errors++; $display("FAIL byte_u latency out_valid got %b want 1", a_out_valid); end
        if (a_out_data !== 32'h000000F4) begin errors++; $display("FAIL byte_u data got %h want 000000F4", a_out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_half_misalign();
        a_out_ready = 1'b1;
        a_send(32'h8001ABCD, 2'd2, 2'd1, 1'b1, {1'b0, 32'hFFFF8001});
        a_send(32'h8001ABCD, 2'd1, 2'd1, 1'b1, {1'b1, 32'h0});
        a_send(32'h8001ABCD, 2'd0, 2'd3, 1'b1, {1'b0, 32'h8001ABCD});
        a_send(32'h8001ABCD, 2'd3, 2'd0, 1'b0, {1'b1, 32'h0});
        @(negedge clk);
        checks += 2;
        if (a_out_misalign !== 1'b1) begin errors++; $display("FAIL full_mis misalign got %b want 1", a_out_misalign); end
        if (a_out_data !== 32'h0) begin errors++; $display("FAIL full_mis data got %h want 0", a_out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [1:0]  o, s;
        logic        sg;
        a_out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d = $urandom; o = 2'($urandom); s = 2'($urandom); sg = 1'($urandom);
            a_send(d, o, s, sg, model_a(d, o, s, sg));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL rand_drain pending got %0d want 0", qa.size()); end
    endtask

    task automatic test_backpressure();
        int p0;
        b_out_ready = 1'b0;
        b_send(64'h0123456789ABCDEF, 3'd0, 2'd2, 1'b0, {1'b0, 64'hEF});
        b_send(64'h0123456789ABCDEF, 3'd1, 2'd2, 1'b0, {1'b0, 64'hCD});
        b_in_data = 64'h0123456789ABCDEF; b_in_off = 3'd2; b_in_size = 2'd2; b_in_signed = 1'b0;
        b_exp = {1'b0, 64'hAB};
        b_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (b_in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready got %b want 0", b_in_ready); end
            if (b_out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid got %b want 1", b_out_valid); end
            if (b_out_data !== 64'hEF) begin errors++; $display("FAIL bp hold data got %h want EF", b_out_data); end
            @(posedge clk); #1;
        end
        p0 = b_pops;
        b_out_ready = 1'b1;
        b_send(64'h0123456789ABCDEF, 3'd2, 2'd2, 1'b0, {1'b0, 64'hAB});
        b_send(64'h0123456789ABCDEF, 3'd3, 2'd2, 1'b1, {1'b0, 64'hFFFFFFFFFFFFFF89});
        repeat (4) @(posedge clk);
        #1;
        checks += 2;
        if (b_pops - p0 != 4) begin errors++; $display("FAIL bp delivered got %0d want 4", b_pops - p0); end
        if (qb.size() != 0) begin errors++; $display("FAIL bp pending got %0d want 0", qb.size()); end
    endtask

    task automatic test_flush();
        int p0;
        b_out_ready = 1'b1;
        p0 = b_pops;
        b_send(64'h1111111111111111, 3'd0, 2'd2, 1'b0, {1'b0, 64'h11});
        b_send(64'h2222222222222222, 3'd0, 2'd2, 1'b0, {1'b0, 64'h22});
        b_in_data = 64'h3333333333333333; b_in_off = 3'd0; b_in_size = 2'd2; b_in_signed = 1'b0;
        b_exp = {1'b0, 64'h33};
        b_in_valid = 1'b1;
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b want 0", b_out_valid); end
        end
        checks++;
        if (b_pops != p0) begin errors++; $display("FAIL flush delivered got %0d want 0", b_pops - p0); end
        @(posedge clk); #1;
    endtask

    task automatic test_wide();
        b_out_ready = 1'b1;
        b_send(64'h8877665544332211, 3'd7, 2'd2, 1'b1, {1'b0, 64'hFFFFFFFFFFFFFF88});
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL wide early out_valid got %b want 0", b_out_valid); end
        @(negedge clk);
        checks += 2;
        if (b_out_valid !== 1'b1) begin errors++; $display("FAIL wide latency out_valid got %b want 1", b_out_valid); end
        if (b_out_data !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL wide byte data got %h want FFFFFFFFFFFFFF88", b_out_data); end
        @(posedge clk); #1;
        b_send(64'h8877665544332211, 3'd6, 2'd1, 1'b0, {1'b0, 64'h8877});
        b_send(64'h8877665544332211, 3'd7, 2'd1, 1'b1, {1'b1, 64'h0});
        b_send(64'h8877665544332211, 3'd4, 2'd1, 1'b1, {1'b0, 64'h6655});
        b_send(64'h8877665544332211, 3'd0, 2'd0, 1'b1, {1'b0, 64'h8877665544332211});
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (qb.size() != 0) begin errors++; $display("FAIL wide pending got %0d want 0", qb.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_off = '0; a_in_size = '0; a_in_signed = 1'b0;
        a_flush = 1'b0; a_out_ready = 1'b1; a_exp = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_off = '0; b_in_size = '0; b_in_signed = 1'b0;
        b_flush = 1'b0; b_out_ready = 1'b1; b_exp = '0;
        test_reset();
        test_byte_signed();
        test_half_misalign();
        test_random();
        test_backpressure();
        test_flush();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
